// File: rtl/pmem_arbiter.sv
// Arbitrates the single physical-memory port between the I-cache and D-cache miss paths.
// D-cache wins by default; a starvation counter forces an I grant after STARVE_MAX D wins.
module pmem_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned LINE_W     = 128,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic              i_pmem_resp,
    output logic [LINE_W-1:0] i_pmem_rdata,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic              d_pmem_resp,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state, state_nxt;
    logic [3:0]        starve_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              write_q;
    logic              d_req, grant_i, grant_d, busy;

    assign d_req = d_pmem_read | d_pmem_write;

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && i_pmem_read && starve_cnt == STARVE_LIM) grant_i = 1'b1;
                else if (d_req)                                     grant_d = 1'b1;
                else if (i_pmem_read)                               grant_i = 1'b1;
                if (grant_i)      state_nxt = I_BUSY;
                else if (grant_d) state_nxt = D_BUSY;
            end
            I_BUSY, D_BUSY: if (pmem_resp) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_i) begin
                addr_q     <= i_pmem_address;
                wdata_q    <= '0;
                write_q    <= 1'b0;
                starve_cnt <= '0;
            end else if (grant_d) begin
                addr_q  <= d_pmem_address;
                wdata_q <= d_pmem_wdata;
                write_q <= d_pmem_write;
                // Count only D wins that actually kept a waiting I-cache out.
                if (!i_pmem_read)                starve_cnt <= '0;
                else if (starve_cnt >= STARVE_LIM) starve_cnt <= STARVE_LIM;
                else                             starve_cnt <= 4'(starve_cnt + 4'd1);
            end
        end
    end

    assign busy         = (state != IDLE);
    assign pmem_read    = busy & ~write_q;
    assign pmem_write   = busy & write_q;
    assign pmem_address = busy ? addr_q  : '0;
    assign pmem_wdata   = busy ? wdata_q : '0;

    assign i_pmem_resp  = (state == I_BUSY) & pmem_resp;
    assign d_pmem_resp  = (state == D_BUSY) & pmem_resp;
    assign i_pmem_rdata = i_pmem_resp ? pmem_rdata : '0;
    assign d_pmem_rdata = d_pmem_resp ? pmem_rdata : '0;

    // Simultaneous fill and writeback requests are a D-cache bug; write is taken.
    a_no_rd_wr: assert property (@(posedge clk) disable iff (!reset)
        !(state == IDLE && d_pmem_read && d_pmem_write));

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed scoreboard bench for pmem_arbiter: expected completions are queued at request
// time and popped when a requester resp pulse appears.
module tb_pmem_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned LW = 128;
    localparam int unsigned SM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_pmem_read, i_pmem_resp;
    logic [AW-1:0] i_pmem_address;
    logic [LW-1:0] i_pmem_rdata;
    logic          d_pmem_read, d_pmem_write, d_pmem_resp;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata, d_pmem_rdata;
    logic          pmem_read, pmem_write, pmem_resp;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata, pmem_rdata;

    always #5 clk = ~clk;

    pmem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_resp(i_pmem_resp), .i_pmem_rdata(i_pmem_rdata),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_resp(d_pmem_resp), .d_pmem_rdata(d_pmem_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    typedef struct packed {
        logic          is_d;
        logic [LW-1:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Memory contents are a fixed function of the line address.
    function automatic logic [LW-1:0] mdata(input logic [AW-1:0] a);
        return {8{a ^ 16'h5A5A}};
    endfunction

    task automatic chk(input string tag, input logic [LW+31:0] obs, input logic [LW+31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic grant_check(input string tag, input int exp_wait, input logic exp_write,
                               input logic [AW-1:0] exp_addr, input logic [LW-1:0] exp_wdata);
        int n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (pmem_read || pmem_write) break;
        end
        chk({tag, "_wait"}, n, exp_wait);
        chk({tag, "_op"}, {pmem_read, pmem_write}, {!exp_write, exp_write});
        chk({tag, "_addr"}, pmem_address, exp_addr);
        if (exp_write) chk({tag, "_wdata"}, pmem_wdata, exp_wdata);
        chk({tag, "_noresp"}, {i_pmem_resp, d_pmem_resp}, 0);
    endtask

    task automatic respond(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        pmem_resp  = 1'b1;
        pmem_rdata = mdata(pmem_address);
        @(negedge clk);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        chk({tag, "_iresp"}, i_pmem_resp, !e.is_d);
        chk({tag, "_dresp"}, d_pmem_resp, e.is_d);
        chk({tag, "_irdata"}, i_pmem_rdata, e.is_d ? '0 : e.rdata);
        chk({tag, "_drdata"}, d_pmem_rdata, e.is_d ? e.rdata : '0);
        @(posedge clk);
        #1;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        chk({tag, "_idle"}, {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}, 0);
    endtask

    initial begin
        reset = 1'b0;
        i_pmem_read = 1'b0; i_pmem_address = '0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
        pmem_resp = 1'b0; pmem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {i_pmem_resp, d_pmem_resp, pmem_read, pmem_write, pmem_address}, 0);
        chk("reset_wdata", pmem_wdata, 0);
        reset = 1'b1;

        // Lone I read, memory answers five clocks after the grant
        step();
        i_pmem_address = 16'h1230; i_pmem_read = 1'b1;
        sb.push_back('{1'b0, mdata(16'h1230)});
        grant_check("t1", 2, 1'b0, 16'h1230, '0);
        repeat (3) @(negedge clk);
        chk("t1_hold", {pmem_read, pmem_address}, {1'b1, 16'h1230});
        respond("t1");
        i_pmem_read = 1'b0;
        idle_check("t1");

        // Simultaneous I and D: D first, I after one IDLE cycle
        step();
        d_pmem_address = 16'h2000; d_pmem_read = 1'b1;
        i_pmem_address = 16'h3000; i_pmem_read = 1'b1;
        sb.push_back('{1'b1, mdata(16'h2000)});
        sb.push_back('{1'b0, mdata(16'h3000)});
        grant_check("t2d", 2, 1'b0, 16'h2000, '0);
        chk("t2_cnt1", dut.starve_cnt, 1);
        respond("t2d");
        d_pmem_read = 1'b0;
        grant_check("t2i", 2, 1'b0, 16'h3000, '0);
        chk("t2_cnt0", dut.starve_cnt, 0);
        respond("t2i");
        i_pmem_read = 1'b0;
        idle_check("t2");

        // D writeback; requester inputs change after grant
        step();
        d_pmem_address = 16'h4000; d_pmem_wdata = {16{8'hA5}}; d_pmem_write = 1'b1;
        sb.push_back('{1'b1, mdata(16'h4000)});
        grant_check("t3", 2, 1'b1, 16'h4000, {16{8'hA5}});
        step();
        d_pmem_wdata = {16{8'h3C}}; d_pmem_address = 16'h4440;
        @(negedge clk);
        chk("t3_wdata_kept", pmem_wdata, {16{8'hA5}});
        chk("t3_addr_kept", pmem_address, 16'h4000);
        respond("t3");
        d_pmem_write = 1'b0; d_pmem_wdata = '0;
        idle_check("t3");

        // Starvation: four D grants while I waits, then a forced I grant
        step();
        i_pmem_address = 16'h1100; i_pmem_read = 1'b1; d_pmem_read = 1'b1;
        for (int k = 0; k < 4; k++) sb.push_back('{1'b1, mdata(16'(16'h5000 + 16 * k))});
        sb.push_back('{1'b0, mdata(16'h1100)});
        for (int k = 0; k < 4; k++) begin
            d_pmem_address = 16'(16'h5000 + 16 * k);
            grant_check("t4d", 2, 1'b0, 16'(16'h5000 + 16 * k), '0);
            chk("t4_cnt", dut.starve_cnt, k + 1);
            respond("t4d");
        end
        grant_check("t4i", 2, 1'b0, 16'h1100, '0);
        chk("t4_cnt_clr", dut.starve_cnt, 0);
        respond("t4i");
        i_pmem_read = 1'b0; d_pmem_read = 1'b0;
        idle_check("t4");

        // Reset two cycles into a D read aborts it silently
        step();
        d_pmem_address = 16'h6000; d_pmem_read = 1'b1;
        grant_check("t5", 2, 1'b0, 16'h6000, '0);
        step();
        #2 reset = 1'b0;
        pmem_resp = 1'b1; pmem_rdata = '1;
        #1;
        chk("t5_abort", {pmem_read, pmem_write, d_pmem_resp, i_pmem_resp, pmem_address}, 0);
        chk("t5_abort_rdata", d_pmem_rdata, 0);
        d_pmem_read = 1'b0; pmem_resp = 1'b0; pmem_rdata = '0;
        @(negedge clk);
        reset = 1'b1;
        step();
        i_pmem_address = 16'h7000; i_pmem_read = 1'b1;
        sb.push_back('{1'b0, mdata(16'h7000)});
        grant_check("t5i", 2, 1'b0, 16'h7000, '0);
        respond("t5i");
        i_pmem_read = 1'b0;
        idle_check("t5");

        // Spurious memory completion while idle
        step();
        pmem_resp = 1'b1; pmem_rdata = '1;
        @(negedge clk);
        chk("t6_resp", {i_pmem_resp, d_pmem_resp, pmem_read, pmem_write}, 0);
        chk("t6_rdata", {i_pmem_rdata, d_pmem_rdata}, 0);
        step();
        pmem_resp = 1'b0; pmem_rdata = '0;
        idle_check("t6");
        step();
        d_pmem_address = 16'h0AB0; d_pmem_read = 1'b1;
        sb.push_back('{1'b1, mdata(16'h0AB0)});
        grant_check("t6d", 2, 1'b0, 16'h0AB0, '0);
        respond("t6d");
        d_pmem_read = 1'b0;
        idle_check("t6d");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
